// File: rtl/pattern_chk_pkg.sv
// Shared definitions for the serial pattern checker: state encoding and parameter defaults.
package pattern_chk_pkg;
    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
    localparam int FRAME_LEN_DEF = 4;
    localparam int CNT_W_DEF     = 8;
endpackage

// File: rtl/pattern_chk_if.sv
// Pattern checker bus: serial input side from the generator, frame results and statistics out.
interface pattern_chk_if import pattern_chk_pkg::*; #(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
);
    logic                 pattern;
    logic                 valid;
    logic [2:0]           exp_sel;
    logic                 clr;
    logic [FRAME_LEN-1:0] data_out;
    logic                 done;
    logic                 match;
    logic                 abort;
    logic [CNT_W-1:0]     frame_cnt;
    logic [CNT_W-1:0]     err_cnt;

    modport master (
        output pattern, valid, exp_sel, clr,
        input  data_out, done, match, abort, frame_cnt, err_cnt
    );
    modport slave (
        input  pattern, valid, exp_sel, clr,
        output data_out, done, match, abort, frame_cnt, err_cnt
    );
endinterface

// File: rtl/pattern_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pattern_chk.sv
// Serial frame receiver: assembles FRAME_LEN bits MSB-first, checks the frame against the
// latched selector, and keeps frame/error statistics.
module pattern_chk import pattern_chk_pkg::*; #(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pattern_chk_if.slave  bus
);
    localparam int BC_W = $clog2(FRAME_LEN + 1);

    state_t               r_state;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [FRAME_LEN-2:0] r_shreg;
    logic [FRAME_LEN-1:0] r_data;
    logic [2:0]           r_exp;
    logic                 r_done;
    logic                 r_match;
    logic                 r_abort;
    logic [CNT_W-1:0]     r_frame_cnt;
    logic [CNT_W-1:0]     w_err_cnt;

    logic [FRAME_LEN-1:0] w_frame;
    logic                 w_last;
    logic                 w_abort;
    logic                 w_match;
    logic                 w_err_inc;

    // Only the pending FRAME_LEN-1 bits are kept; the incoming bit completes the frame.
    assign w_frame   = {r_shreg, bus.pattern};
    assign w_last    = (r_state == RECV) && bus.valid && (r_bit_cnt == BC_W'(FRAME_LEN - 1));
    // In RECV bit_cnt is always 1..FRAME_LEN-1, so any valid gap truncates the frame.
    assign w_abort   = (r_state == RECV) && !bus.valid;
    assign w_match   = (w_frame[FRAME_LEN-1] == w_frame[FRAME_LEN-2]) && (w_frame[2:0] == r_exp);
    assign w_err_inc = (w_last && !w_match) || w_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_exp     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid) begin
                        r_shreg   <= w_frame[FRAME_LEN-2:0];
                        r_bit_cnt <= BC_W'(1);
                        r_exp     <= bus.exp_sel;
                        r_state   <= RECV;
                    end
                end
                RECV: begin
                    if (bus.valid) begin
                        r_shreg <= w_frame[FRAME_LEN-2:0];
                        if (w_last) begin
                            r_data    <= w_frame;
                            r_match   <= w_match;
                            r_done    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end else begin
                        r_abort   <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_frame_cnt <= '0;
        else if (bus.clr)
            r_frame_cnt <= '0;
        else if (w_last)
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end

    sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err_inc),
        .i_clr (bus.clr),
        .o_cnt (w_err_cnt)
    );

    assign bus.data_out  = r_data;
    assign bus.done      = r_done;
    assign bus.match     = r_match;
    assign bus.abort     = r_abort;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = w_err_cnt;
endmodule

// File: tb/tb_pattern_chk.sv
// Bench for pattern_chk: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a frame-level reference model.
module tb_pattern_chk;
    localparam int FL = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pattern_chk_if #(.FRAME_LEN(FL), .CNT_W(CW)) bus();

    pattern_chk #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: collects bits of the current frame in a queue.
    bit           q[$];
    logic [2:0]   m_exp   = '0;
    logic [FL-1:0] m_data = '0;
    logic         m_match = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_abort = 1'b0;
    int           m_fcnt  = 0;
    int           m_ecnt  = 0;
    bit           m_fin, m_einc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_exp = '0; m_data = '0; m_match = 1'b0; m_done = 1'b0; m_abort = 1'b0;
            m_fcnt = 0; m_ecnt = 0;
        end else begin
            m_fin = 0; m_einc = 0; m_done = 1'b0; m_abort = 1'b0;
            if (bus.valid) begin
                if (q.size() == 0) m_exp = bus.exp_sel;
                q.push_back(bus.pattern);
                if (q.size() == FL) begin
                    for (int i = 0; i < FL; i++) m_data[FL-1-i] = q[i];
                    m_match = (m_data[3] == m_data[2]) && (m_data[2:0] == m_exp);
                    m_done  = 1'b1;
                    m_fin   = 1;
                    m_einc  = !m_match;
                    q.delete();
                end
            end else if (q.size() != 0) begin
                m_abort = 1'b1;
                m_einc  = 1;
                q.delete();
            end
            if (bus.clr) begin
                m_fcnt = 0; m_ecnt = 0;
            end else begin
                if (m_fin) m_fcnt = (m_fcnt + 1) % (1 << CW);
                if (m_einc && m_ecnt < (1 << CW) - 1) m_ecnt++;
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if (bus.data_out !== m_data || bus.match !== m_match || bus.done !== m_done ||
            bus.abort !== m_abort || bus.frame_cnt !== CW'(m_fcnt) || bus.err_cnt !== CW'(m_ecnt) ||
            (bus.done && bus.abort)) begin
            fails++;
            $display("FAIL model t=%0t got data=%b match=%b done=%b abort=%b fcnt=%0d ecnt=%0d want data=%b match=%b done=%b abort=%b fcnt=%0d ecnt=%0d",
                     $time, bus.data_out, bus.match, bus.done, bus.abort, bus.frame_cnt, bus.err_cnt,
                     m_data, m_match, m_done, m_abort, m_fcnt, m_ecnt);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic v);
        bus.pattern = b;
        bus.valid   = v;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) send_bit(bits[i], 1'b1);
    endtask

    initial begin
        bus.pattern = 1'b0; bus.valid = 1'b0; bus.exp_sel = 3'b000; bus.clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", int'(bus.data_out), 0);
        check("rst_cnts", int'(bus.frame_cnt) + int'(bus.err_cnt), 0);
        rst = 1'b0;
        send_bit(1'b0, 1'b0);

        // Scenario 1: good frame
        bus.exp_sel = 3'b101;
        send_frame(4'b1101);
        check("s1_done", int'(bus.done), 1);
        check("s1_data", int'(bus.data_out), 4'b1101);
        check("s1_match", int'(bus.match), 1);
        check("s1_fcnt", int'(bus.frame_cnt), 1);
        check("s1_ecnt", int'(bus.err_cnt), 0);
        send_bit(1'b0, 1'b0);
        check("s1_match_held", int'(bus.match), 1);

        // Scenario 2: format error
        send_frame(4'b0101);
        check("s2_done", int'(bus.done), 1);
        check("s2_data", int'(bus.data_out), 4'b0101);
        check("s2_match", int'(bus.match), 0);
        check("s2_ecnt", int'(bus.err_cnt), 1);
        send_bit(1'b0, 1'b0);

        // Scenario 3: truncated frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("s3_abort", int'(bus.abort), 1);
        check("s3_done", int'(bus.done), 0);
        check("s3_ecnt", int'(bus.err_cnt), 2);
        check("s3_data", int'(bus.data_out), 4'b0101);
        send_bit(1'b0, 1'b0);
        check("s3_abort_1cyc", int'(bus.abort), 0);

        // Scenario 4: back-to-back, selector changes mid-frame
        bus.clr = 1'b1;
        send_bit(1'b0, 1'b0);
        bus.clr = 1'b0;
        bus.exp_sel = 3'b111;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        bus.exp_sel = 3'b010;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        check("s4_done1", int'(bus.done), 1);
        check("s4_match1", int'(bus.match), 1);
        bus.exp_sel = 3'b000;
        send_bit(1'b0, 1'b1);
        bus.exp_sel = 3'b111;
        check("s4_gap", int'(bus.done), 0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check("s4_done2", int'(bus.done), 1);
        check("s4_match2", int'(bus.match), 1);
        check("s4_fcnt", int'(bus.frame_cnt), 2);
        send_bit(1'b0, 1'b0);

        // Scenario 5: saturation then clear on completing edge
        repeat (255) begin
            send_bit(1'b1, 1'b1);
            send_bit(1'b0, 1'b0);
        end
        check("s5_sat", int'(bus.err_cnt), 255);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("s5_sat_hold", int'(bus.err_cnt), 255);
        bus.exp_sel = 3'b101;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        bus.clr = 1'b1;
        send_bit(1'b1, 1'b1);
        bus.clr = 1'b0;
        check("s5_clr_done", int'(bus.done), 1);
        check("s5_clr_fcnt", int'(bus.frame_cnt), 0);
        check("s5_clr_ecnt", int'(bus.err_cnt), 0);
        check("s5_clr_data", int'(bus.data_out), 4'b1101);
        send_bit(1'b0, 1'b0);

        // Scenario 6: async reset mid-frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        bus.pattern = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("s6_rst_data", int'(bus.data_out), 0);
        check("s6_rst_match", int'(bus.match), 0);
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b0, 1'b0);
        check("s6_no_abort", int'(bus.abort), 0);
        bus.exp_sel = 3'b101;
        send_frame(4'b1101);
        check("s6_done", int'(bus.done), 1);
        check("s6_match", int'(bus.match), 1);
        check("s6_fcnt", int'(bus.frame_cnt), 1);
        send_bit(1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bus.exp_sel = 3'($urandom_range(0, 7));
            bus.clr     = ($urandom_range(0, 999) == 0);
            send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
        end
        bus.clr = 1'b0;
        send_bit(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pattern_chk.md
PATTERN_CHK -- requirements
Module: pattern_chk

Interface
REQ-001 The block SHALL have the parameter FRAME_LEN, default 4, giving the number of serial bits per frame.
REQ-002 The block SHALL have the parameter CNT_W, default 8, giving the width of the frame and error counters.
REQ-003 The block SHALL have the port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have the port pattern, input, 1 bit: serial data bit from the upstream pattern generator.
REQ-006 The block SHALL have the port valid, input, 1 bit: qualifies pattern; one bit is sampled per clock while high.
REQ-007 The block SHALL have the port exp_sel, input, 3 bits: expected selector, compared against the recovered frame.
REQ-008 The block SHALL have the port clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-009 The block SHALL have the port data_out, output, FRAME_LEN bits: last completed frame, first-received bit in the MSB.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-011 The block SHALL have the port match, output, 1 bit: result of the last completed frame; valid when done=1 and held afterwards.
REQ-012 The block SHALL have the port abort, output, 1 bit: one-cycle pulse marking a truncated frame.
REQ-013 The block SHALL have the port frame_cnt, output, CNT_W bits: count of completed frames; wraps.
REQ-014 The block SHALL have the port err_cnt, output, CNT_W bits: count of mismatched plus aborted frames; saturates.

Function
REQ-015 The FSM SHALL have the states IDLE and RECV; all outputs SHALL be registered.
REQ-016 In IDLE, an edge with valid=1 SHALL shift pattern into shreg, set bit_cnt=1, latch exp_sel into exp_q, and go to RECV.
REQ-017 In RECV, an edge with valid=1 SHALL shift pattern in MSB-first and increment bit_cnt.
REQ-018 On the edge sampling bit FRAME_LEN, the block SHALL update data_out and match, set done=1 for one cycle, increment frame_cnt, and go to IDLE. Latency: done is high in the cycle immediately after the last valid bit is presented.
REQ-019 match SHALL be 1 iff data_out[3]==data_out[2] (format check for the duplicated leading selector bit) and data_out[2:0]==exp_q.
REQ-020 When match=0 at completion, err_cnt SHALL increment.
REQ-021 In RECV, an edge with valid=0 and bit_cnt in 1..FRAME_LEN-1 SHALL discard the frame, pulse abort for one cycle, increment err_cnt, and go to IDLE. In that case data_out, match and frame_cnt SHALL be unchanged.
REQ-022 Back-to-back frames: valid held high past bit FRAME_LEN SHALL start a new frame on the next edge (IDLE rule), with no lost bit.
REQ-023 frame_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 err_cnt SHALL saturate at 2^CNT_W-1.
REQ-025 clr=1 SHALL zero frame_cnt and err_cnt on that edge, overriding any same-edge increment. clr SHALL NOT affect the FSM, shreg, data_out or match.
REQ-026 exp_sel changes mid-frame SHALL be ignored; only the value latched at bit 1 is used.
REQ-027 done and abort SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 SHALL force state=IDLE, bit_cnt=0, shreg=0, data_out=0, done=0, match=0, abort=0, frame_cnt=0 and err_cnt=0 immediately, independent of clk.
REQ-029 A reset mid-frame SHALL discard the partial frame without an abort pulse.
REQ-030 After rst deasserts, the first valid=1 edge SHALL start a fresh frame.

Structure
REQ-031 The shared package SHALL hold the state encoding (IDLE=1'b0, RECV=1'b1), the FRAME_LEN default and the CNT_W default.
REQ-032 The sub-module sat_cnt (CNT_W-bit, inc/clr inputs, saturating) SHALL implement err_cnt.
REQ-033 frame_cnt SHALL be inline logic.

Verification
REQ-034 Scenario 1: exp_sel=3'b101; feed valid=1 for 4 cycles with bits 1,1,0,1 -> next cycle done=1, data_out=4'b1101, match=1, frame_cnt=1, err_cnt=0.
REQ-035 Scenario 2: exp_sel=3'b101; feed bits 0,1,0,1 -> done=1, data_out=4'b0101, match=0 (format error), err_cnt=1.
REQ-036 Scenario 3: valid=1 for 2 bits, then valid=0 -> abort=1 for exactly one cycle; done stays 0; err_cnt +1; data_out unchanged.
REQ-037 Scenario 4: valid held high for 8 cycles with bits 1,1,1,1,0,0,0,0 and exp_sel=3'b111 then 3'b000 -> two done pulses 4 cycles apart; match=1 both times; frame_cnt=2.
REQ-038 Scenario 5: preload err_cnt=255 with 255 aborts, then one more abort -> err_cnt stays 255. Then assert clr on the same edge as a completing frame -> frame_cnt=0, err_cnt=0.
REQ-039 Scenario 6: assert rst asynchronously after bit 2 of a frame -> all outputs 0 immediately, with no abort pulse. A following 4-bit frame completes normally.
